// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered fetch PC with trap/redirect/call/return/stall
// next-PC selection and a circular return-address stack (overwrites oldest when full).
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h80,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         STALL,
    input  logic                         TRAP,
    input  logic                         REDIRECT,
    input  logic [WIDTH-1:0]             TARGET,
    input  logic                         CALL,
    input  logic                         RET,
    output logic [WIDTH-1:0]             PC_out,
    output logic [WIDTH-1:0]             PC_plus,
    output logic [$clog2(RAS_DEPTH):0]   RAS_COUNT,
    output logic                         RAS_UNDERFLOW
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             uflow_q, uflow_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic             push, pop;
    logic [WIDTH-1:0] ras_top;

    assign PC_plus       = pc_q + WIDTH'(INC);
    assign PC_out        = pc_q;
    assign RAS_COUNT     = count_q;
    assign RAS_UNDERFLOW = uflow_q;
    // Most recent push sits just below the write pointer.
    assign ras_top       = ras_q[ptr_q - PW'(1)];

    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        uflow_d = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;

        if (TRAP) begin
            pc_d = TRAP_VECTOR;
        end else if (REDIRECT) begin
            pc_d = TARGET;
            push = CALL;
        end else if (RET && (count_q != '0)) begin
            pc_d = ras_top;
            pop  = 1'b1;
        end else begin
            uflow_d = RET;
            if (!STALL) begin
                pc_d = PC_plus;
            end
        end

        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q    <= RESET_VECTOR;
            ptr_q   <= '0;
            count_q <= '0;
            uflow_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            uflow_q <= uflow_d;
        end
    end

    // Stack storage carries no reset; contents are only meaningful below RAS_COUNT.
    always_ff @(posedge CLK) begin
        if (RST_N && push) begin
            ras_q[ptr_q] <= PC_plus;
        end
    end

endmodule
